// File: rtl/regfile_pkg.sv
// Shared widths, index/data types and the zero-register index for regfile_sb.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with a running popcount and a sticky WAW flag.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  ADDR_W   = ADDR_W_DEF,
  parameter int  ZERO_REG = 1,
  localparam int DEPTH    = 2**ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              pend_set_i,
  input  logic [ADDR_W-1:0] pend_addr_i,
  output logic [DEPTH-1:0]  pending_o,
  output logic [ADDR_W:0]   pend_count_o,
  output logic              waw_err_o
);

  logic [DEPTH-1:0] pending_q, pending_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             waw_q, waw_d;
  logic             set_ok_s, clr_ok_s, same_idx_s, inc_s, dec_s;
  logic [DEPTH-1:0] set_mask_s, clr_mask_s;

  // Next-state for pending bits, counter and WAW flag
  always_comb begin
    set_ok_s   = pend_set_i && !((ZERO_REG != 0) && (pend_addr_i == ADDR_W'(REG_ZERO)));
    clr_ok_s   = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == ADDR_W'(REG_ZERO)));
    same_idx_s = (wr_addr_i == pend_addr_i);
    set_mask_s = set_ok_s ? ({{(DEPTH-1){1'b0}}, 1'b1} << pend_addr_i) : {DEPTH{1'b0}};
    clr_mask_s = clr_ok_s ? ({{(DEPTH-1){1'b0}}, 1'b1} << wr_addr_i) : {DEPTH{1'b0}};
    // Set is applied after clear so a reissue on the retiring index stays pending
    pending_d  = (pending_q & ~clr_mask_s) | set_mask_s;
    inc_s      = set_ok_s && !pending_q[pend_addr_i];
    dec_s      = clr_ok_s && pending_q[wr_addr_i] && !(set_ok_s && same_idx_s);
    case ({inc_s, dec_s})
      2'b10:   count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{ADDR_W{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    waw_d = waw_q || (set_ok_s && pending_q[pend_addr_i] && !(clr_ok_s && same_idx_s));
  end

  // Scoreboard state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= {DEPTH{1'b0}};
      count_q   <= {(ADDR_W+1){1'b0}};
      waw_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      waw_q     <= waw_d;
    end
  end

  assign pending_o    = pending_q;
  assign pend_count_o = count_q;
  assign waw_err_o    = waw_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = DATA_W_DEF,
  parameter int  ADDR_W   = ADDR_W_DEF,
  parameter int  ZERO_REG = 1,
  localparam int DEPTH    = 2**ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic              rd_busy_a_o,
  output logic              rd_busy_b_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              pend_set_i,
  input  logic [ADDR_W-1:0] pend_addr_i,
  output logic [ADDR_W:0]   pend_count_o,
  output logic              waw_err_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pending_s;
  logic              wr_ok_s;

  function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
    return (ZERO_REG != 0) && (idx == ADDR_W'(REG_ZERO));
  endfunction

  // Returns {busy, data} for one read port
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] idx);
    logic [DATA_W:0] r;
    if (is_zero(idx)) begin
      r = {1'b0, {DATA_W{1'b0}}};
`ifdef RF_BYPASS_EN
    end else if (wr_ok_s && (wr_addr_i == idx)) begin
      r = {1'b0, wr_data_i};
`endif
    end else begin
      r = {pending_s[idx], mem_q[idx]};
    end
    return r;
  endfunction

  assign wr_ok_s = wr_en_i && !is_zero(wr_addr_i);

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .pend_set_i   (pend_set_i),
    .pend_addr_i  (pend_addr_i),
    .pending_o    (pending_s),
    .pend_count_o (pend_count_o),
    .waw_err_o    (waw_err_o)
  );

  // Register storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read ports (forwarding applied inside read_port) and stored-only debug read
  always_comb begin
    {rd_busy_a_o, rd_data_a_o} = read_port(rd_addr_a_i);
    {rd_busy_b_o, rd_data_b_o} = read_port(rd_addr_b_i);
    if (is_zero(dbg_addr_i)) begin
      dbg_data_o = {DATA_W{1'b0}};
    end else begin
      dbg_data_o = mem_q[dbg_addr_i];
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with an integrated pending-write scoreboard. It is the single-cycle CPU's next-generation register file. It adds an asynchronous clear, a hardwired zero register, optional write-to-read forwarding, and per-register busy tracking for long-latency writebacks such as loads. It sits between decode (read ports, busy query, pending issue) and writeback (write port). A debug port exposes one register to the testbench.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and pending sets
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- rd_addr_a / rd_addr_b  in  ADDR_W  read port indices
- rd_data_a / rd_data_b  out  DATA_W  read data (combinational)
- rd_busy_a / rd_busy_b  out  1  indexed register has a write in flight
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- pend_set  in  1  mark pend_addr as in flight (long-latency op issued)
- pend_addr  in  ADDR_W  index to mark
- pend_count  out  ADDR_W+1  number of registers currently pending
- waw_err  out  1  sticky: pend_set hit an already-pending register
- dbg_addr  in  ADDR_W  debug index
- dbg_data  out  DATA_W  debug read, registered value only, never forwarded

## Operation
- Storage: 2**ADDR_W x DATA_W flops plus one pending bit per register.
- Write: on the clock edge with wr_en=1, `reg[wr_addr] <= wr_data` and `pending[wr_addr] <= 0`. With ZERO_REG=1 and wr_addr=0, nothing happens.
- Pending set: on the edge with pend_set=1, `pending[pend_addr] <= 1`. This is ignored for index 0 when ZERO_REG=1.
- Simultaneous wr_en and pend_set to the same index: the data is written and pending ends at 1 (set wins, because a new producer was issued as the old one retired).
- WAW detection: if pend_set targets a register whose pending bit is already 1, and that bit is not being cleared in the same cycle, waw_err <= 1. waw_err stays 1 until reset.
- pend_count: registered and equal to popcount(pending) at all times. It updates by +1, -1, or 0 per cycle, covering set/clear on different indices, the same index, and no-op cases.
- Read: rd_data_x = reg[rd_addr_x]. With ZERO_REG=1 and index 0, data=0 and busy=0.
- Busy: rd_busy_x = pending[rd_addr_x], subject to forwarding (see Configuration).
- Reset (async assert): all registers 0, all pending bits 0, pend_count=0, waw_err=0. Outputs reflect this immediately. Normal operation resumes on the first edge after deassertion.

## Timing
- Read data and busy are combinational from the addresses; zero latency.
- Write, pending and counter state are visible one edge after the strobe (without forwarding).
- The pending bit clears on the writeback edge; the counter follows on the same edge.
- Reset mid-operation discards all in-flight pending state; later writebacks to those indices are plain writes and leave the counter unchanged.

## Configuration
- RF_BYPASS_EN defined:
  - If wr_en=1, wr_addr==rd_addr_x, and the index is not zero-reg, then rd_data_x=wr_data and rd_busy_x=0 in the same cycle.
  - Port A has priority over no port; each read port forwards independently.
- RF_BYPASS_EN undefined:
  - Reads return the pre-edge stored value.
  - Busy reflects the stored pending bit only.
  - A same-cycle read after write sees old data and busy=1.
- Neither setting affects dbg_data.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W constants
  - typedefs reg_idx_t (ADDR_W) and reg_data_t (DATA_W)
  - localparam REG_ZERO=0
- One sub-module: regfile_scoreboard. It owns the pending bits, pend_count and waw_err.
- The read-mux and forwarding logic stay in the top module.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert rst_n=0 mid-cycle -> rd_data(r5)=0 immediately, pend_count=0, waw_err=0.
- Zero register: wr_en to r0 with 0x1234, and pend_set r0 -> rd_data(r0)=0, rd_busy=0, pend_count=0.
- Scoreboard: pend_set r3 -> next cycle rd_busy(r3)=1, pend_count=1.
  - Writeback r3=0xA5A5A5A5 -> busy=0, count=0, data=0xA5A5A5A5.
- Simultaneous events:
  - Writeback r3 plus pend_set r3 in the same cycle -> data updated, busy stays 1, count unchanged, waw_err=0.
  - pend_set r3 while r3 is pending with no writeback -> waw_err=1 and stays sticky.
- Forwarding, r7 holds 0x11, write r7=0x22 while reading r7 on both ports in the same cycle:
  - With RF_BYPASS_EN: both ports read 0x22, busy=0.
  - Without it: both ports read 0x11.
  - In both builds, dbg_data=0x11 that cycle.
- Counter stress: pend_set r1..r31 on consecutive cycles -> pend_count=31. Then writeback all -> pend_count=0 with no wrap.
